writeback_stage: RTL and testbench



---
 rtl/wisc_pkg.sv | 17 +
 rtl/mem_wb_reg.sv | 38 +++
 rtl/writeback_stage.sv | 122 ++++++++++++
 tb/tb_writeback_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared constants for the processor pipeline: writeback source codes,
// the hard-wired zero register id and the halt state encodings.
package wisc_pkg;

    // Writeback source select; 2'b11 is reserved and yields zero.
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC2 = 2'b10;

    // Register $zero: writes to it are always dropped.
    localparam logic [3:0] REG_ZERO = 4'd0;

    // Processor run/halt states.
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/mem_wb_reg.sv
// Enable/clear pipeline register holding the concatenated MEM/WB fields.
// Clear beats enable; with neither asserted the register holds.
module mem_wb_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] fields_q;
    logic [W-1:0] fields_d;

    // Next value: bubble on clear, new data on enable, otherwise hold.
    always_comb begin
        fields_d = fields_q;
        if (clr) begin
            fields_d = '0;
        end else if (en) begin
            fields_d = d;
        end
    end

    // Register with asynchronous active-low reset to all zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fields_q <= '0;
        end else begin
            fields_q <= fields_d;
        end
    end

    assign q = fields_q;

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register plus writeback datapath driving the register
// file write port. Also owns the halt state and the retired-instruction
// counter.
module writeback_stage
    import wisc_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int REG_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_valid,
    input  logic                mem_reg_write,
    input  logic [REG_ID_W-1:0] mem_dst_reg,
    input  logic [1:0]          mem_wb_sel,
    input  logic [DATA_W-1:0]   mem_alu_result,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [DATA_W-1:0]   mem_pc_plus2,
    input  logic                mem_halt,
    input  logic                wb_stall,
    input  logic                wb_flush,
    output logic                write_reg,
    output logic [REG_ID_W-1:0] dst_reg,
    output logic [DATA_W-1:0]   dst_data,
    output logic                halted,
    output logic [15:0]         retire_count
);

    localparam int FIELDS_W = 1 + 1 + REG_ID_W + 2 + 3 * DATA_W + 1;

    logic [FIELDS_W-1:0] mem_fields;
    logic [FIELDS_W-1:0] wb_fields;

    logic                wb_valid;
    logic                wb_reg_write;
    logic [REG_ID_W-1:0] wb_dst_reg;
    logic [1:0]          wb_sel;
    logic [DATA_W-1:0]   wb_alu_result;
    logic [DATA_W-1:0]   wb_rdata;
    logic [DATA_W-1:0]   wb_pc_plus2;
    logic                wb_halt;

    logic                capture_en;
    logic                capture_clr;
    logic                retire;

    logic [0:0]          state_q;
    logic [0:0]          state_d;
    logic [15:0]         count_q;
    logic [15:0]         count_d;

    assign mem_fields = {mem_valid, mem_reg_write, mem_dst_reg, mem_wb_sel,
                         mem_alu_result, mem_rdata, mem_pc_plus2, mem_halt};

    assign {wb_valid, wb_reg_write, wb_dst_reg, wb_sel,
            wb_alu_result, wb_rdata, wb_pc_plus2, wb_halt} = wb_fields;

    assign halted = (state_q == ST_HALTED);

    // Once halted the WB register is frozen; flush outranks stall.
    assign capture_clr = ~halted & wb_flush;
    assign capture_en  = ~halted & ~wb_stall;

    mem_wb_reg #(
        .W (FIELDS_W)
    ) u_mem_wb_reg (
        .clk   (clk),
        .rst_n (rst),
        .en    (capture_en),
        .clr   (capture_clr),
        .d     (mem_fields),
        .q     (wb_fields)
    );

    // Writeback source mux; the reserved select code returns zero.
    always_comb begin
        dst_data = '0;
        case (wb_sel)
            WB_ALU:  dst_data = wb_alu_result;
            WB_MEM:  dst_data = wb_rdata;
            WB_PC2:  dst_data = wb_pc_plus2;
            default: dst_data = '0;
        endcase
    end

    // $zero writes are suppressed so the file's bypass never forwards them.
    assign dst_reg   = wb_dst_reg;
    assign write_reg = wb_valid & wb_reg_write
                     & (wb_dst_reg != REG_ID_W'(REG_ZERO)) & ~halted;

    // An occupant retires when WB moves on (new content or bubble); an HLT
    // retires on the edge that halts the processor, stalled or not.
    assign retire = ~halted & wb_valid & (wb_flush | ~wb_stall | wb_halt);

    // Next state and counter: HALTED is sticky until reset, counter wraps.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (state_q == ST_RUN) begin
            if (wb_valid && wb_halt) begin
                state_d = ST_HALTED;
            end
            if (retire) begin
                count_d = count_q + 16'd1;
            end
        end
    end

    // State and counter flops with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign retire_count = count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: expected write-port transactions are
// queued as each instruction is driven and compared once it reaches WB.
module tb_writeback_stage;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [3:0]  mem_dst_reg;
    logic [1:0]  mem_wb_sel;
    logic [15:0] mem_alu_result;
    logic [15:0] mem_rdata;
    logic [15:0] mem_pc_plus2;
    logic        mem_halt;
    logic        wb_stall;
    logic        wb_flush;
    logic        write_reg;
    logic [3:0]  dst_reg;
    logic [15:0] dst_data;
    logic        halted;
    logic [15:0] retire_count;

    typedef struct {
        logic        we;
        logic [3:0]  dst;
        logic [15:0] data;
        logic        full;   // 0: only write_reg is checked
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    writeback_stage #(
        .DATA_W   (16),
        .REG_ID_W (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_dst_reg    (mem_dst_reg),
        .mem_wb_sel     (mem_wb_sel),
        .mem_alu_result (mem_alu_result),
        .mem_rdata      (mem_rdata),
        .mem_pc_plus2   (mem_pc_plus2),
        .mem_halt       (mem_halt),
        .wb_stall       (wb_stall),
        .wb_flush       (wb_flush),
        .write_reg      (write_reg),
        .dst_reg        (dst_reg),
        .dst_data       (dst_data),
        .halted         (halted),
        .retire_count   (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one MEM-stage instruction, queue its expected write-port image,
    // clock it into WB and compare against the oldest queued expectation.
    task automatic step(input string tag,
                        input logic v, input logic rw, input logic [3:0] dst,
                        input logic [1:0] sel, input logic [15:0] alu,
                        input logic [15:0] rd, input logic [15:0] pc2,
                        input logic hlt,
                        input logic e_we, input logic [3:0] e_dst,
                        input logic [15:0] e_data, input logic e_full);
        exp_t e;
        mem_valid      = v;
        mem_reg_write  = rw;
        mem_dst_reg    = dst;
        mem_wb_sel     = sel;
        mem_alu_result = alu;
        mem_rdata      = rd;
        mem_pc_plus2   = pc2;
        mem_halt       = hlt;
        e.we = e_we; e.dst = e_dst; e.data = e_data; e.full = e_full;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".write_reg"}, {15'd0, write_reg}, {15'd0, e.we});
        if (e.full) begin
            check({tag, ".dst_reg"}, {12'd0, dst_reg}, {12'd0, e.dst});
            check({tag, ".dst_data"}, dst_data, e.data);
        end
        $display("txn %-12s we=%b dst=%0d data=%h halted=%b count=%h",
                 tag, write_reg, dst_reg, dst_data, halted, retire_count);
    endtask

    task automatic bubble(input string tag);
        step(tag, 1'b0, 1'b0, 4'd0, 2'b00, 16'h0, 16'h0, 16'h0, 1'b0,
             1'b0, 4'd0, 16'h0, 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        mem_valid = 0; mem_reg_write = 0; mem_dst_reg = 0; mem_wb_sel = 0;
        mem_alu_result = 0; mem_rdata = 0; mem_pc_plus2 = 0; mem_halt = 0;
        wb_stall = 0; wb_flush = 0;
        #1;
        check("rst.write_reg", {15'd0, write_reg}, 16'd0);
        check("rst.dst_reg", {12'd0, dst_reg}, 16'd0);
        check("rst.dst_data", dst_data, 16'd0);
        check("rst.halted", {15'd0, halted}, 16'd0);
        check("rst.count", retire_count, 16'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // ALU write to R3
        step("alu_r3", 1, 1, 4'd3, 2'b00, 16'h1234, 16'h5555, 16'h6666, 0,
             1, 4'd3, 16'h1234, 1);
        check("alu.count_before", retire_count, 16'd0);
        bubble("bub1");
        check("alu.count_after", retire_count, 16'd1);

        // R0 write is dropped but still retires
        step("r0_drop", 1, 1, 4'd0, 2'b00, 16'hBEEF, 16'h0, 16'h0, 0,
             0, 4'd0, 16'hBEEF, 1);
        bubble("bub2");
        check("r0.count", retire_count, 16'd2);

        // Source select: MEM, PC2, reserved
        step("load_r5", 1, 1, 4'd5, 2'b01, 16'hAAAA, 16'h00FF, 16'h1111, 0,
             1, 4'd5, 16'h00FF, 1);
        step("pcs_r15", 1, 1, 4'd15, 2'b10, 16'hAAAA, 16'hBBBB, 16'h0042, 0,
             1, 4'd15, 16'h0042, 1);
        step("sel11_r6", 1, 1, 4'd6, 2'b11, 16'h1111, 16'h2222, 16'h3333, 0,
             1, 4'd6, 16'h0000, 1);
        bubble("bub3");
        check("sel.count", retire_count, 16'd5);

        // Stall 3 cycles with R7 in WB: 4 write cycles, counted once
        step("r7", 1, 1, 4'd7, 2'b00, 16'h7777, 16'h0, 16'h0, 0,
             1, 4'd7, 16'h7777, 1);
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("r7_stall", 1, 1, 4'd9, 2'b00, 16'h9999, 16'h0, 16'h0, 0,
                 1, 4'd7, 16'h7777, 1);
        end
        check("stall.count_held", retire_count, 16'd5);
        wb_stall = 1'b0;
        bubble("bub4");
        check("stall.count_once", retire_count, 16'd6);

        // Flush together with stall loads a bubble; occupant retires
        step("r8", 1, 1, 4'd8, 2'b00, 16'h8888, 16'h0, 16'h0, 0,
             1, 4'd8, 16'h8888, 1);
        wb_stall = 1'b1; wb_flush = 1'b1;
        step("flush", 1, 1, 4'd9, 2'b00, 16'h9999, 16'h0, 16'h0, 0,
             0, 4'd0, 16'h0000, 1);
        wb_stall = 1'b0; wb_flush = 1'b0;
        check("flush.count", retire_count, 16'd7);
        bubble("bub5");
        check("flush.count_after", retire_count, 16'd7);

        // HLT then a write to R2 that must never happen
        step("hlt", 1, 0, 4'd0, 2'b00, 16'h0, 16'h0, 16'h0, 1,
             0, 4'd0, 16'h0, 0);
        check("hlt.halted_k", {15'd0, halted}, 16'd0);
        step("r2_after", 1, 1, 4'd2, 2'b00, 16'h2222, 16'h0, 16'h0, 0,
             0, 4'd2, 16'h2222, 0);
        check("hlt.halted", {15'd0, halted}, 16'd1);
        check("hlt.count", retire_count, 16'd8);
        step("r2_again", 1, 1, 4'd2, 2'b00, 16'h2222, 16'h0, 16'h0, 0,
             0, 4'd2, 16'h2222, 0);
        check("hlt.count_frozen", retire_count, 16'd8);

        // Asynchronous reset mid-cycle
        #2;
        rst = 1'b0;
        #1;
        check("arst.halted", {15'd0, halted}, 16'd0);
        check("arst.count", retire_count, 16'd0);
        check("arst.write_reg", {15'd0, write_reg}, 16'd0);
        check("arst.dst_data", dst_data, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // Wrap: 0x10000 consecutive valid retirements
        mem_valid = 1; mem_reg_write = 0; mem_dst_reg = 4'd1; mem_halt = 0;
        mem_wb_sel = 2'b00;
        for (int i = 0; i < 65536; i++) begin
            @(posedge clk);
        end
        #1;
        check("wrap.ffff", retire_count, 16'hFFFF);
        $display("txn %-12s count=%h", "wrap_ffff", retire_count);
        @(posedge clk); #1;
        check("wrap.zero", retire_count, 16'h0000);
        $display("txn %-12s count=%h", "wrap_zero", retire_count);
        mem_valid = 0;

        check("sb.empty", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
